// File: rtl/eth_buf_pkg.sv
// Shared definitions for the receive packet buffer.
// Holds the buffer sizing constants, the descriptor record posted to the
// AXI fetch side, and the packet writer state encoding.
package eth_buf_pkg;

    localparam int DEPTH      = 2048;  // SRAM depth in 64-bit words
    localparam int ADDR_W     = 11;    // log2(DEPTH)
    localparam int MAX_WORDS  = 192;   // longest accepted packet in words
    localparam int DESC_DEPTH = 4;     // descriptor FIFO entries

    // Descriptor: start word address and byte length of one committed packet.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       len;
    } desc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/eth_desc_fifo.sv
// Synchronous first-word-fall-through FIFO of packet descriptors.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   push, push_data write one descriptor (ignored when full)
//   pop             consume the head descriptor (ignored when empty)
//   head            current head entry, valid whenever empty is low
//   full, empty     occupancy flags
//   count           registered occupancy
module eth_desc_fifo
    import eth_buf_pkg::*;
#(
    parameter  int N_ENTRIES = DESC_DEPTH,
    localparam int IDX_W     = $clog2(N_ENTRIES),
    localparam int CNT_W     = IDX_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  desc_t            push_data,
    input  logic             pop,
    output desc_t            head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    desc_t            mem_r [N_ENTRIES];
    logic [IDX_W-1:0] wr_idx_r;
    logic [IDX_W-1:0] rd_idx_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CNT_W'(N_ENTRIES));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign count  = count_r;
    assign head   = mem_r[rd_idx_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Storage, indices and occupancy; simultaneous push and pop keep count steady.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_r <= {IDX_W{1'b0}};
            rd_idx_r <= {IDX_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_idx_r] <= push_data;
                wr_idx_r        <= wr_idx_r + IDX_W'(1);
            end
            if (pop_s) begin
                rd_idx_r <= rd_idx_r + IDX_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/eth_rx_pkt_writer.sv
// Receive-side packet writer in front of the packet SRAM (circular buffer).
// Each packet is written contiguously from wr_base; it is committed on an
// error-free eop that fits, which posts {start address, byte length} to the
// descriptor FIFO. Dropped packets roll wr_cur back to wr_base.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   rx_valid/sop/eop/be/err/data       MAC receive stream, no backpressure
//   mem_write, mem_wr_addr, mem_data   registered SRAM write port
//   rd_ptr                             consumer free pointer (address + wrap bit)
//   desc_valid/ready/addr/len          descriptor handshake to the fetch side
//   drop_cnt                           dropped packets, saturating
//   pkt_cnt                            committed packets, wrapping
module eth_rx_pkt_writer #(
    parameter int DEPTH      = eth_buf_pkg::DEPTH,
    parameter int ADDR_W     = eth_buf_pkg::ADDR_W,
    parameter int MAX_WORDS  = eth_buf_pkg::MAX_WORDS,
    parameter int DESC_DEPTH = eth_buf_pkg::DESC_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic [2:0]        rx_be,
    input  logic              rx_err,
    input  logic [63:0]       rx_data,
    output logic              mem_write,
    output logic [31:0]       mem_wr_addr,
    output logic [63:0]       mem_data,
    input  logic [ADDR_W:0]   rd_ptr,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [ADDR_W-1:0] desc_addr,
    output logic [15:0]       desc_len,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       pkt_cnt
);

    import eth_buf_pkg::*;

    localparam int PTR_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(DESC_DEPTH) + 1;

    wr_state_e        state_r, state_s;
    logic [PTR_W-1:0] wr_base_r, wr_cur_r;
    logic [15:0]      wcount_r;
    logic             push_pend_r;
    desc_t            pend_desc_r;

    logic [PTR_W-1:0] next_base_s, next_cur_s, wr_addr_s;
    logic [15:0]      next_wcount_s, commit_len_s;
    logic             wr_en_s, commit_s, space_full_s, base_full_s, desc_full_s;
    logic [1:0]       drop_amt_s;
    logic [3:0]       be_bytes_s;
    logic [16:0]      drop_sum_s;
    desc_t            commit_desc_s, fifo_head_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    assign space_full_s = ((wr_cur_r - rd_ptr) == PTR_W'(DEPTH));
    assign base_full_s  = ((wr_base_r - rd_ptr) == PTR_W'(DEPTH));
    // A commit still waiting in push_pend_r already owns a FIFO slot.
    assign desc_full_s  = ((fifo_count_s + CNT_W'(push_pend_r)) >= CNT_W'(DESC_DEPTH));
    assign be_bytes_s   = (rx_be == 3'd0) ? 4'd8 : {1'b0, rx_be};
    assign drop_sum_s   = {1'b0, drop_cnt} + {15'd0, drop_amt_s};

    // Next-state, pointer updates, write strobe and commit decision per beat.
    always_comb begin
        state_s       = state_r;
        next_base_s   = wr_base_r;
        next_cur_s    = wr_cur_r;
        next_wcount_s = wcount_r;
        wr_en_s       = 1'b0;
        wr_addr_s     = wr_cur_r;
        drop_amt_s    = 2'd0;
        commit_s      = 1'b0;
        commit_len_s  = 16'd0;
        if (rx_valid && rx_sop) begin
            // An open packet is abandoned; the new one restarts at wr_base.
            drop_amt_s = (state_r == WRITE) ? 2'd1 : 2'd0;
            next_cur_s = wr_base_r;
            if (desc_full_s || base_full_s) begin
                drop_amt_s = (state_r == WRITE) ? 2'd2 : 2'd1;
                state_s    = rx_eop ? IDLE : DROP;
            end else begin
                wr_en_s       = 1'b1;
                wr_addr_s     = wr_base_r;
                next_wcount_s = 16'd1;
                if (!rx_eop) begin
                    next_cur_s = wr_base_r + PTR_W'(1);
                    state_s    = WRITE;
                end else if (rx_err) begin
                    drop_amt_s = drop_amt_s + 2'd1;
                    state_s    = IDLE;
                end else begin
                    commit_s     = 1'b1;
                    commit_len_s = {12'd0, be_bytes_s};
                    next_cur_s   = wr_base_r + PTR_W'(1);
                    next_base_s  = wr_base_r + PTR_W'(1);
                    state_s      = IDLE;
                end
            end
        end else if (rx_valid) begin
            case (state_r)
                WRITE: begin
                    if (space_full_s || (wcount_r == 16'(MAX_WORDS))) begin
                        drop_amt_s = 2'd1;
                        next_cur_s = wr_base_r;
                        state_s    = rx_eop ? IDLE : DROP;
                    end else begin
                        wr_en_s       = 1'b1;
                        next_cur_s    = wr_cur_r + PTR_W'(1);
                        next_wcount_s = wcount_r + 16'd1;
                        if (!rx_eop) begin
                            state_s = WRITE;
                        end else if (rx_err) begin
                            drop_amt_s = 2'd1;
                            next_cur_s = wr_base_r;
                            state_s    = IDLE;
                        end else begin
                            // Words before this one are full 8-byte words.
                            commit_s     = 1'b1;
                            commit_len_s = {wcount_r[12:0], 3'b000} + {12'd0, be_bytes_s};
                            next_base_s  = wr_cur_r + PTR_W'(1);
                            state_s      = IDLE;
                        end
                    end
                end
                DROP: begin
                    state_s = rx_eop ? IDLE : DROP;
                end
                IDLE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Descriptor for the packet being committed on this beat.
    always_comb begin
        commit_desc_s                  = '0;
        commit_desc_s.addr[ADDR_W-1:0] = wr_base_r[ADDR_W-1:0];
        commit_desc_s.len              = commit_len_s;
    end

    // State, pointers, counters and the registered SRAM write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            wr_base_r   <= {PTR_W{1'b0}};
            wr_cur_r    <= {PTR_W{1'b0}};
            wcount_r    <= 16'd0;
            push_pend_r <= 1'b0;
            pend_desc_r <= '0;
            mem_write   <= 1'b0;
            mem_wr_addr <= 32'd0;
            mem_data    <= 64'd0;
            drop_cnt    <= 16'd0;
            pkt_cnt     <= 16'd0;
        end else begin
            state_r     <= state_s;
            wr_base_r   <= next_base_s;
            wr_cur_r    <= next_cur_s;
            wcount_r    <= next_wcount_s;
            // Held one cycle so the last word is in the SRAM before the descriptor shows.
            push_pend_r <= commit_s;
            pend_desc_r <= commit_desc_s;
            mem_write   <= wr_en_s;
            if (wr_en_s) begin
                mem_wr_addr <= {{(32-ADDR_W){1'b0}}, wr_addr_s[ADDR_W-1:0]};
                mem_data    <= rx_data;
            end else begin
                mem_wr_addr <= mem_wr_addr;
                mem_data    <= mem_data;
            end
            drop_cnt <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
            pkt_cnt  <= pkt_cnt + {15'd0, commit_s};
        end
    end

    eth_desc_fifo #(
        .N_ENTRIES (DESC_DEPTH)
    ) u_desc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_pend_r),
        .push_data (pend_desc_r),
        .pop       (desc_ready),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign desc_valid = ~fifo_empty_s;
    assign desc_addr  = fifo_head_s.addr[ADDR_W-1:0];
    assign desc_len   = fifo_head_s.len;

endmodule

// File: doc/eth_rx_pkt_writer.md
Name: eth_rx_pkt_writer

Overview:
Receive-side packet writer that sits directly upstream of the 2048 x 64-bit packet SRAM. It takes the MAC receive word stream and writes each packet contiguously into the SRAM, which it manages as a circular buffer. A packet is committed only when its last word arrives error-free and fits. For each committed packet it posts a descriptor (start word address, byte length) to the AXI fetch side. The AXI fetch side frees space by advancing its read pointer.

Parameters:
DEPTH, 2048, SRAM depth in 64-bit words; power of two.
ADDR_W, 11, log2(DEPTH).
MAX_WORDS, 192, longest accepted packet in words; longer packets are dropped.
DESC_DEPTH, 4, descriptor FIFO entries; power of two.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
rx_valid  in  1  beat valid; there is no backpressure, so every valid beat must be consumed.
rx_sop  in  1  first word of packet; qualified by rx_valid.
rx_eop  in  1  last word of packet; qualified by rx_valid. sop and eop may be set on the same beat.
rx_be  in  3  valid bytes in the eop word; 0 means 8.
rx_err  in  1  packet error (CRC etc.); sampled on the eop beat.
rx_data  in  64  packet word; byte 0 in bits [7:0].
mem_write  out  1  SRAM write strobe.
mem_wr_addr  out  32  SRAM word address, zero-extended from ADDR_W bits.
mem_data  out  64  SRAM write data.
rd_ptr  in  ADDR_W+1  consumer's free pointer: the word address plus a wrap bit. It must only advance.
desc_valid  out  1  descriptor available.
desc_ready  in  1  consumer accepts the descriptor.
desc_addr  out  ADDR_W  start word address of the packet.
desc_len  out  16  packet length in bytes.
drop_cnt  out  16  count of dropped packets; saturates at 0xFFFF.
pkt_cnt  out  16  count of committed packets; wraps.

Behaviour:
- Reset: all outputs are 0. wr_base = wr_cur = 0, the descriptor FIFO is empty, and the FSM is in IDLE. A reset mid-packet discards that packet silently and does not increment drop_cnt.
- Pointers are ADDR_W+1 bits wide.
  - used = wr_cur - rd_ptr, computed modulo 2^(ADDR_W+1).
  - full = (used == DEPTH).
  - The SRAM address is the low ADDR_W bits of the pointer; wrap-around is natural.
- FSM states: IDLE, WRITE, DROP.
  - IDLE, beat with sop:
    - If the descriptor FIFO is full, go to DROP. No write is issued.
    - Otherwise write the word at wr_cur, set wr_cur+1 and wcount=1, and go to WRITE. If eop is also set, the packet commits immediately and the FSM stays in IDLE.
  - IDLE, beat without sop: ignored; no count change.
  - WRITE, beat without sop: if full or wcount == MAX_WORDS, set wr_cur = wr_base, drop_cnt+1, and go to DROP. Otherwise write the word and increment wr_cur and wcount.
  - WRITE, beat with eop (accepted): commit if rx_err=0. Otherwise set wr_cur = wr_base, drop_cnt+1, and go to IDLE.
  - WRITE, beat with sop: the current packet is dropped (wr_cur = wr_base, drop_cnt+1). The new beat is then handled as if in IDLE, with its first word written at the old wr_base.
  - DROP: discard beats until eop, then go to IDLE. A sop beat in DROP is handled as if in IDLE.
- Commit sequence:
  - Push {wr_base[ADDR_W-1:0], len} into the descriptor FIFO.
  - len = (wcount-1)*8 + (rx_be==0 ? 8 : rx_be).
  - Set wr_base = wr_cur after the final increment.
  - pkt_cnt+1.
- SRAM write timing: mem_write, mem_wr_addr and mem_data are registered and asserted exactly 1 cycle after the accepted beat. No write is issued in DROP, or when full.
- Descriptor timing:
  - desc_valid rises 2 cycles after the committing eop beat, guaranteeing the last word is in the SRAM before the consumer's read.
  - Transfer occurs when desc_valid and desc_ready are both high. The FIFO is first-word-fall-through.
  - A push and a pop in the same cycle are both honoured.
  - The FIFO-full check uses registered occupancy, counting the pending push.
- Space is never overwritten before rd_ptr passes it. Words written for a dropped packet lie beyond wr_base and are harmless.

Decomposition:
- Package eth_buf_pkg: the DEPTH/ADDR_W/MAX_WORDS constants, the typedef desc_t {addr, len}, and the enum wr_state_e {IDLE, WRITE, DROP}.
- One sub-module, eth_desc_fifo: a synchronous FWFT FIFO of desc_t with DESC_DEPTH entries and push/pop/full/empty signals.

Test Plan:
1. After reset, send 3 words (sop on beat 0, eop on beat 2, rx_be=5) with desc_ready=1 -> mem writes to addresses 0,1,2 on cycles N+1..N+3; desc_addr=0 and desc_len=21 appear at N+4; pkt_cnt=1.
2. With DEPTH=16, drive wr_base to 14 and rd_ptr to 14, then send a 4-word packet -> writes land at 14,15,0,1; desc_addr=14, desc_len=32.
3. With DEPTH=16 and rd_ptr held at 0, send a 20-word packet -> 16 writes, then no further writes; drop_cnt=1; no descriptor; the next packet is written starting at address 0.
4. Send a 2-word packet with rx_err=1 on eop, then a good 1-word packet (rx_be=0) -> drop_cnt=1; a single descriptor with addr=0, len=8.
5. With desc_ready=0, send five 1-word packets -> four descriptors are queued; the fifth produces no mem_write and drop_cnt=1; raising desc_ready pops addresses 0,1,2,3 in order.
6. Send 3 beats without eop, then a new sop packet of 2 words -> drop_cnt=1; the second packet is written at 0,1; desc_len=16.
